// File: rtl/blvds_pkg.sv
// Shared definitions for the BLVDS frame link: state encoding, bus field layout
// and default control words. Used by both the transmitter and the receiver side.
package blvds_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_HEAD      = 3'd2,
    ST_PAYLOAD   = 3'd3,
    ST_CHKSUM    = 3'd4,
    ST_EPIL      = 3'd5,
    ST_GAP       = 3'd6
  } txState_t;

  localparam int          FRAME_BIT  = 17;
  localparam int          CTRL_BIT   = 16;
  localparam logic [15:0] DEF_HEADER = 16'hF0F0;
  localparam logic [15:0] DEF_EPILOG = 16'h0F0F;
  localparam logic [17:0] BUS_IDLE   = 18'h0_0000;

  // Builds an in-frame bus word; the frame-active flag is always set.
  function automatic logic [17:0] busWord(input logic ctrl, input logic [15:0] word);
    logic [17:0] w;
    w            = BUS_IDLE;
    w[FRAME_BIT] = 1'b1;
    w[CTRL_BIT]  = ctrl;
    w[15:0]      = word;
    return w;
  endfunction

endpackage

// File: rtl/blvds_frame_tx.sv
// BLVDS frame transmitter: drains a show-ahead FIFO into fixed-length frames.
// Optional checksum word before the epilog when BLVDS_TX_CHECKSUM_EN is defined.
module blvds_frame_tx
  import blvds_pkg::*;
#(
  parameter int          FRAME_LEN = 256,
  parameter logic [15:0] HEADER    = DEF_HEADER,
  parameter logic [15:0] EPILOG    = DEF_EPILOG,
  parameter int          GAP       = 8
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  input  logic [15:0] iFIFO_DATA,
  input  logic        iEMPTY,
  input  logic [8:0]  iUSEDW,
  output logic        oRD_REQ,
  output logic [17:0] oDATA_BLVDS,
  output logic        oBUSY,
  output logic [15:0] oFRAME_CNT,
  output logic        oUNDERRUN
);

  localparam logic [8:0] LAST_WORD = 9'(FRAME_LEN - 1);
  localparam logic [8:0] USEDW_MIN = 9'(FRAME_LEN);
  localparam logic [7:0] GAP_LAST  = 8'(GAP - 1);

  txState_t    stateR;
  txState_t    nextStateS;
  logic [8:0]  wordCntR;
  logic [7:0]  gapCntR;
  logic        pendingR;
  logic        pendingNextS;
  logic [17:0] dataR;
  logic [17:0] dataNextS;
  logic        busyR;
  logic        busyNextS;
  logic [15:0] frameCntR;
  logic        underrunR;
  logic        rdReqS;
  logic        underrunS;
  logic        frameDoneS;
  logic        lastWordS;
  logic        gapDoneS;
`ifdef BLVDS_TX_CHECKSUM_EN
  logic [15:0] sumR;
`endif

  // State register.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      stateR <= ST_IDLE;
    end else begin
      stateR <= nextStateS;
    end
  end

  // Next-state decode and next bus word.
  always_comb begin
    nextStateS = stateR;
    dataNextS  = BUS_IDLE;
    rdReqS     = 1'b0;
    underrunS  = 1'b0;
    frameDoneS = 1'b0;
    lastWordS  = (wordCntR == LAST_WORD);
    gapDoneS   = (gapCntR == GAP_LAST);
    case (stateR)
      ST_IDLE: begin
        if (iSTART) begin
          nextStateS = ST_WAIT_DATA;
        end else begin
          nextStateS = ST_IDLE;
        end
      end
      ST_WAIT_DATA: begin
        // Only start once a whole frame is buffered, so the payload never stalls.
        if (iUSEDW >= USEDW_MIN) begin
          nextStateS = ST_HEAD;
        end else begin
          nextStateS = ST_WAIT_DATA;
        end
      end
      ST_HEAD: begin
        dataNextS  = busWord(1'b1, HEADER);
        nextStateS = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        if (iEMPTY) begin
          dataNextS = busWord(1'b0, 16'h0000);
          underrunS = 1'b1;
        end else begin
          dataNextS = busWord(1'b0, iFIFO_DATA);
          rdReqS    = 1'b1;
        end
        if (lastWordS) begin
`ifdef BLVDS_TX_CHECKSUM_EN
          nextStateS = ST_CHKSUM;
`else
          nextStateS = ST_EPIL;
`endif
        end else begin
          nextStateS = ST_PAYLOAD;
        end
      end
      ST_CHKSUM: begin
`ifdef BLVDS_TX_CHECKSUM_EN
        dataNextS  = busWord(1'b0, sumR);
        nextStateS = ST_EPIL;
`else
        nextStateS = ST_IDLE;
`endif
      end
      ST_EPIL: begin
        dataNextS  = busWord(1'b1, EPILOG);
        frameDoneS = 1'b1;
        nextStateS = ST_GAP;
      end
      ST_GAP: begin
        // A request arriving exactly on the last gap cycle is served like a pending one.
        if (gapDoneS) begin
          if (pendingR || iSTART) begin
            nextStateS = ST_WAIT_DATA;
          end else begin
            nextStateS = ST_IDLE;
          end
        end else begin
          nextStateS = ST_GAP;
        end
      end
      default: begin
        nextStateS = ST_IDLE;
      end
    endcase
  end

  // Busy follows the next state; pending request is one deep.
  always_comb begin
    busyNextS = (nextStateS != ST_IDLE);
    if ((stateR == ST_GAP) && gapDoneS) begin
      pendingNextS = 1'b0;
    end else if (busyR && iSTART) begin
      pendingNextS = 1'b1;
    end else begin
      pendingNextS = pendingR;
    end
  end

  // Registered outputs, word/gap counters and pending flag.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      dataR     <= BUS_IDLE;
      busyR     <= 1'b0;
      underrunR <= 1'b0;
      pendingR  <= 1'b0;
      frameCntR <= 16'h0000;
      wordCntR  <= 9'd0;
      gapCntR   <= 8'd0;
    end else begin
      dataR     <= dataNextS;
      busyR     <= busyNextS;
      underrunR <= underrunS;
      pendingR  <= pendingNextS;
      if (frameDoneS) begin
        frameCntR <= frameCntR + 16'd1;
      end else begin
        frameCntR <= frameCntR;
      end
      if (stateR == ST_HEAD) begin
        wordCntR <= 9'd0;
      end else if (stateR == ST_PAYLOAD) begin
        wordCntR <= wordCntR + 9'd1;
      end else begin
        wordCntR <= wordCntR;
      end
      if (stateR == ST_EPIL) begin
        gapCntR <= 8'd0;
      end else if (stateR == ST_GAP) begin
        gapCntR <= gapCntR + 8'd1;
      end else begin
        gapCntR <= gapCntR;
      end
    end
  end

`ifdef BLVDS_TX_CHECKSUM_EN
  // Running sum of payload words exactly as placed on the bus (underrun zeros included).
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      sumR <= 16'h0000;
    end else if (stateR == ST_HEAD) begin
      sumR <= 16'h0000;
    end else if (stateR == ST_PAYLOAD) begin
      sumR <= sumR + dataNextS[15:0];
    end else begin
      sumR <= sumR;
    end
  end
`endif

  assign oRD_REQ     = rdReqS;
  assign oDATA_BLVDS = dataR;
  assign oBUSY       = busyR;
  assign oFRAME_CNT  = frameCntR;
  assign oUNDERRUN   = underrunR;

endmodule
